// File: rtl/delay_steer_loader.sv
// Steering-frame loader: collects NUM_CH clamped delay words into a shadow bank and
// commits them to the delay-line bus together on the next sample_tick.
module delay_steer_loader #(
    parameter int NUM_CH    = 8,
    parameter int MAX_DELAY = 64,
    parameter int DW        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DW-1:0]        cfg_data,
    input  logic                 cfg_last,
    output logic [NUM_CH*DW-1:0] delay_bus,
    output logic                 delay_update,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 clamp_sticky,
    input  logic                 clamp_clr
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};
    localparam logic [IW-1:0] ONE_IDX  = IW'(1'b1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
    localparam logic [DW-1:0] MAX_W    = DW'(MAX_DELAY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [NUM_CH-1:0][DW-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0][DW-1:0] bus_q, bus_d;
    logic                      upd_q, upd_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;
    logic                      sticky_q, sticky_d;
    logic                      accept_s;
    logic                      over_s;
    logic [DW-1:0]             word_s;

    function automatic logic exceeds_max(input logic [DW-1:0] d);
        return (d > MAX_W);
    endfunction

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
        return exceeds_max(d) ? MAX_W : d;
    endfunction

    assign cfg_ready = (state_q != PEND);
    assign accept_s  = cfg_valid && cfg_ready;
    assign over_s    = exceeds_max(cfg_data);
    assign word_s    = clamp_delay(cfg_data);

    // Next-state, shadow-bank and output-pulse logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        bus_d    = bus_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (cfg_last) begin
                        err_d = 1'b1;
                        idx_d = ZERO_IDX;
                    end else begin
                        shadow_d[0] = word_s;
                        idx_d       = ONE_IDX;
                        state_d     = LOAD;
                    end
                end else begin
                    idx_d = ZERO_IDX;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    shadow_d[idx_q] = word_s;
                    if (idx_q == LAST_IDX) begin
                        idx_d = ZERO_IDX;
                        if (cfg_last) begin
                            state_d = PEND;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (cfg_last) begin
                        err_d   = 1'b1;
                        idx_d   = ZERO_IDX;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + ONE_IDX;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            DRAIN: begin
                if (accept_s && cfg_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            PEND: begin
                // Only a tick seen while already pending commits the bank.
                if (sample_tick) begin
                    bus_d   = shadow_q;
                    upd_d   = 1'b1;
                    idx_d   = ZERO_IDX;
                    state_d = IDLE;
                end else begin
                    state_d = PEND;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = ZERO_IDX;
            end
        endcase

        if (accept_s && over_s) begin
            sticky_d = 1'b1;
        end else if (clamp_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; async reset clears the active bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= ZERO_IDX;
            shadow_q <= '0;
            bus_q    <= '0;
            upd_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            bus_q    <= bus_d;
            upd_q    <= upd_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign delay_bus    = bus_q;
    assign delay_update = upd_q;
    assign busy         = busy_q;
    assign cfg_err      = err_q;
    assign clamp_sticky = sticky_q;

endmodule

// File: tb/tb_delay_steer_loader.sv
// Bench for delay_steer_loader: directed scenarios plus random frames checked against
// a frame-level reference model (frame length decides commit or error).
module tb_delay_steer_loader;

    localparam int NUM_CH    = 8;
    localparam int MAX_DELAY = 64;
    localparam int DW        = 32;
    localparam int BW        = NUM_CH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_tick = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_last = 1'b0;
    logic          clamp_clr = 1'b0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_ready, delay_update, busy, cfg_err, clamp_sticky;
    logic [BW-1:0] delay_bus;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    int upd_seen = 0;

    logic [BW-1:0] exp_bus = '0;
    logic          exp_sticky = 1'b0;
    int            exp_err = 0;
    int            exp_upd = 0;
    logic [DW-1:0] words [0:15];

    always #5 clk = ~clk;

    delay_steer_loader #(.NUM_CH(NUM_CH), .MAX_DELAY(MAX_DELAY), .DW(DW)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .cfg_last(cfg_last), .delay_bus(delay_bus), .delay_update(delay_update),
        .busy(busy), .cfg_err(cfg_err), .clamp_sticky(clamp_sticky),
        .clamp_clr(clamp_clr)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (cfg_err === 1'b1) err_seen++;
        if (delay_update === 1'b1) upd_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rnd_tick);
        for (int i = 0; i < n; i++) begin
            sample_tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc();
        end
        sample_tick = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input logic clr, input logic tick);
        int guard;
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 20) begin
            cyc();
            guard++;
        end
        chk1("ready_before_word", cfg_ready, 1'b1);
        cfg_valid   = 1'b1;
        cfg_data    = d;
        cfg_last    = last;
        clamp_clr   = clr;
        sample_tick = tick;
        cyc();
        cfg_valid   = 1'b0;
        cfg_last    = 1'b0;
        clamp_clr   = 1'b0;
        sample_tick = 1'b0;
        cfg_data    = '0;
    endtask

    task automatic gen_words(input int len, input bit allow_big);
        for (int i = 0; i < len; i++) begin
            if (allow_big && $urandom_range(0, 3) == 0) words[i] = $urandom;
            else words[i] = DW'($urandom_range(0, MAX_DELAY));
        end
    endtask

    // Sends a frame of len words (cfg_last on the final one) and checks its outcome.
    task automatic run_frame(input int len, input bit gaps, input bit tick_last,
                             input int clr_at, input int wait_n);
        logic [BW-1:0] exp_pend;
        logic          tk;
        int            w;
        exp_pend = '0;
        for (int i = 0; i < len; i++) begin
            if (gaps) idle($urandom_range(0, 3), 1'b1);
            tk = (i == len - 1) ? tick_last : (gaps ? 1'($urandom_range(0, 1)) : 1'b0);
            send_word(words[i], (i == len - 1), (i == clr_at), tk);
        end
        for (int i = 0; i < len; i++) begin
            if (words[i] > DW'(MAX_DELAY)) exp_sticky = 1'b1;
            else if (i == clr_at) exp_sticky = 1'b0;
        end
        if (len == NUM_CH) begin
            for (int k = 0; k < NUM_CH; k++)
                exp_pend[k*DW +: DW] = (words[k] > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : words[k];
            chk1("busy_pend", busy, 1'b1);
            chk1("ready_pend", cfg_ready, 1'b0);
            chkw("bus_hold_pend", delay_bus, exp_bus);
            w = (wait_n < 0) ? $urandom_range(0, 4) : wait_n;
            idle(w, 1'b0);
            chkw("bus_hold_wait", delay_bus, exp_bus);
            chk1("busy_wait", busy, 1'b1);
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            exp_bus = exp_pend;
            exp_upd++;
            chkw("bus_commit", delay_bus, exp_bus);
            chk1("upd_pulse", delay_update, 1'b1);
            chk1("busy_commit", busy, 1'b0);
            chk1("ready_commit", cfg_ready, 1'b1);
            cyc();
            chk1("upd_single", delay_update, 1'b0);
        end else begin
            exp_err++;
            chk1("busy_err", busy, 1'b0);
            chk1("ready_err", cfg_ready, 1'b1);
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            chkw("bus_after_err", delay_bus, exp_bus);
            chk1("no_upd_err", delay_update, 1'b0);
        end
        chk1("sticky", clamp_sticky, exp_sticky);
        chki("err_count", err_seen, exp_err);
        chki("upd_count", upd_seen, exp_upd);
    endtask

    initial begin
        int len;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chkw("rst_bus", delay_bus, '0);
        chk1("rst_ready", cfg_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_upd", delay_update, 1'b0);
        chk1("rst_err", cfg_err, 1'b0);
        chk1("rst_sticky", clamp_sticky, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk1("post_rst_upd", delay_update, 1'b0);
        chk1("post_rst_busy", busy, 1'b0);

        // Ramp frame, tick five cycles after the last word
        for (int k = 0; k < NUM_CH; k++) words[k] = DW'(k);
        run_frame(NUM_CH, 1'b0, 1'b0, -1, 4);

        // Clamping; clamp_clr with a clamped word loses to the set
        gen_words(NUM_CH, 1'b0);
        words[2] = 32'd200;
        words[5] = 32'hFFFF_FFFF;
        run_frame(NUM_CH, 1'b0, 1'b0, 5, -1);
        clamp_clr = 1'b1;
        cyc();
        clamp_clr = 1'b0;
        exp_sticky = 1'b0;
        chk1("sticky_cleared", clamp_sticky, 1'b0);

        // Short and long frames
        gen_words(4, 1'b0);
        run_frame(4, 1'b0, 1'b0, -1, -1);
        chk1("short_ready", cfg_ready, 1'b1);
        gen_words(10, 1'b0);
        run_frame(10, 1'b0, 1'b0, -1, -1);
        gen_words(1, 1'b0);
        run_frame(1, 1'b0, 1'b0, -1, -1);

        // Tick on the last-word edge does not commit
        gen_words(NUM_CH, 1'b1);
        run_frame(NUM_CH, 1'b0, 1'b1, -1, -1);

        // Gap-free then gapped delivery of the same frame
        gen_words(NUM_CH, 1'b1);
        run_frame(NUM_CH, 1'b0, 1'b0, -1, -1);
        for (int k = 0; k < NUM_CH; k++) words[k + 8] = words[k];
        gen_words(NUM_CH, 1'b0);
        run_frame(NUM_CH, 1'b0, 1'b0, -1, 0);
        for (int k = 0; k < NUM_CH; k++) words[k] = words[k + 8];
        run_frame(NUM_CH, 1'b1, 1'b0, -1, -1);

        // Reset while pending
        gen_words(NUM_CH, 1'b0);
        for (int i = 0; i < NUM_CH; i++) send_word(words[i], (i == NUM_CH - 1), 1'b0, 1'b0);
        chk1("pend_before_rst", busy, 1'b1);
        rst = 1'b1;
        #1;
        exp_bus = '0;
        exp_sticky = 1'b0;
        chkw("rst_pend_bus", delay_bus, exp_bus);
        chk1("rst_pend_busy", busy, 1'b0);
        chk1("rst_pend_ready", cfg_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        gen_words(NUM_CH, 1'b0);
        run_frame(NUM_CH, 1'b0, 1'b0, -1, -1);

        // Random frames
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 9) < 6) len = NUM_CH;
            else len = $urandom_range(1, NUM_CH + 3);
            gen_words(len, (len == NUM_CH));
            run_frame(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
